ohc9_mod_accumulator: RTL
=========================

# ohc9_mod_accumulator

- Sequential modulo-9 accumulator in the one-hot code (OHC) domain of the RNS modulo adder.
- Sits directly downstream of the binary-to-9-OHC encoder. It accepts a stream of 9-bit one-hot residues over a valid/ready handshake and adds them modulo 9 by cyclic rotation, with no carry chain.
- At the end of each frame it presents the sum as a canonical one-hot code and as a 4-bit binary value.

## Interface

Parameters:
- CNT_W, default 8: width of the operand counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand present on in_ohc
- in_ready  output  1  block accepts an operand this cycle
- in_ohc  input  9  one-hot residue; bit k set means residue k; all-zero means residue 0
- in_last  input  1  qualifies the accepted operand as the last of its frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream consumes the result
- out_ohc  output  9  canonical one-hot sum; residue 0 is 9'b000000001
- out_bin  output  4  binary sum, 0..8
- out_count  output  CNT_W  number of operands accepted in the frame
- out_err  output  1  at least one malformed code in the frame

## Operation

- Two states, ACCUM and HOLD. Reset enters ACCUM with:
  - acc = 9'b000000001, cnt = 0, err = 0
  - out_valid = 0, out_ohc = 9'b000000001, out_bin = 0, out_count = 0, out_err = 0
- in_ready = 1 exactly when the state is ACCUM. It is a registered-state decode with no combinational path from out_ready.
- Accept means in_valid && in_ready at a rising edge. On accept in ACCUM:
  - k = residue of in_ohc; acc <= acc rotated left by k positions within 9 bits (bit 8 wraps to bit 0).
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
- Accept with in_last = 1:
  - Load out_ohc with the post-rotation acc, out_bin with its bit index, out_count with the post-increment cnt, and out_err with the updated err.
  - Set out_valid = 1 and enter HOLD.
- HOLD:
  - in_ready = 0; all out_* signals are held stable.
  - On out_ready = 1: out_valid <= 0; acc, cnt and err return to their reset values; state returns to ACCUM.
  - The out_ohc/out_bin/out_count/out_err values remain readable after out_valid falls.
- Malformed code: two or more bits of in_ohc set. Handling is set by the configuration macro.
- An all-zero code is always legal and adds 0.
- in_valid without accept: in_ohc and in_last are ignored; nothing changes.

## Timing

- Latency: last operand accepted at edge T, so out_valid = 1 after edge T (visible in cycle T+1).
- Throughput: one operand per cycle in ACCUM. Minimum gap between frames is one cycle, because HOLD lasts at least one cycle.
- After the out_ready edge E in HOLD, in_ready = 1 in cycle E+1.
- A frame with a single in_last operand is legal; its result is that operand's residue, with out_count = 1.
- cnt saturation does not affect the accumulation.
- Asynchronous reset mid-frame or in HOLD discards the partial sum and the pending result immediately. All outputs take their reset values without waiting for a clock edge.

## Configuration

- OHC9_CHECK_EN defined:
  - A malformed code sets err and leaves acc unrotated.
  - cnt still increments and in_last still closes the frame.
  - out_err reports the frame's err.
- OHC9_CHECK_EN undefined:
  - No detection logic; out_err is tied to 0.
  - k is the index of the lowest set bit of in_ohc.

## Test plan

- Residues 3, 7, 5 (in_ohc 9'h008, 9'h080, 9'h020; in_last on the third) -> out_ohc 9'b001000000, out_bin 6, out_count 3, out_err 0, out_valid one cycle after the third accept.
- Operands 9'h000, 9'h000 with in_last -> out_ohc 9'b000000001, out_bin 0, out_count 2.
- Wrap-around, 8 then 1 (9'h100, 9'h002) -> out_ohc 9'b000000001, out_bin 0. Then 8, 8 -> out_bin 7.
- Frame 2, 9'h014 (malformed), 4:
  - With OHC9_CHECK_EN -> out_bin 6, out_err 1, out_count 3.
  - Without OHC9_CHECK_EN -> out_bin 8 (2+2+4), out_err 0.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD -> outputs stable, in_ready 0. On out_ready = 1 -> out_valid 0 next cycle, in_ready 1, and the next frame starts from residue 0.
- Assert rst_n = 0 after 2 of 3 operands -> outputs immediately at reset values. Resending the full frame 3, 7, 5 -> out_bin 6.

Source files
------------

// File: rtl/ohc9_mod_accumulator_if.sv
// Handshake bundle for ohc9_mod_accumulator: operand stream in, frame result out.
// master drives operands and out_ready; slave is the accumulator itself.
interface ohc9_mod_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       in_ohc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       out_ohc;
  logic [3:0]       out_bin;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  modport master (
    output in_valid, in_ohc, in_last, out_ready,
    input  in_ready, out_valid, out_ohc, out_bin, out_count, out_err
  );

  modport slave (
    input  in_valid, in_ohc, in_last, out_ready,
    output in_ready, out_valid, out_ohc, out_bin, out_count, out_err
  );
endinterface

// File: rtl/ohc9_mod_accumulator.sv
// Modulo-9 accumulator on one-hot residues: addition is a cyclic rotation of a one-hot register.
// Define OHC9_CHECK_EN to flag malformed (multi-bit) codes and skip them; otherwise the lowest set bit is used.
module ohc9_mod_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ohc9_mod_accumulator_if.slave        bus
);

  typedef enum logic {ACCUM, HOLD} state_e;

  localparam logic [8:0]       OHC_ZERO = 9'b000000001;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [8:0]       acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [8:0]       out_ohc_q;
  logic [3:0]       out_bin_q;
  logic [CNT_W-1:0] out_count_q;

  logic             accept;
  logic             release_res;
  logic             in_ready;
  logic [3:0]       k;
  logic [8:0]       acc_rot;
  logic [8:0]       acc_step;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_step;

  function automatic logic [3:0] ohc_to_bin(input logic [8:0] v);
    ohc_to_bin = '0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) ohc_to_bin = 4'(i);
    end
  endfunction

  assign accept      = bus.in_valid && in_ready;
  assign release_res = (state_q == HOLD) && bus.out_ready;

  // Residue of the incoming code: index of its lowest set bit, 0 for the all-zero code.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    k = '0;
    for (int i = 8; i >= 0; i--) begin
      if (bus.in_ohc[i]) k = 4'(i);
    end
  end

  // Rotate left by k within 9 bits: the top half of the doubled word shifted by k.
  assign acc_rot = 9'(({acc_q, acc_q} << k) >> 9);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef OHC9_CHECK_EN
  logic err_q;
  logic malformed;

  assign malformed = (bus.in_ohc & (bus.in_ohc - 9'd1)) != 9'd0;
  assign acc_step  = malformed ? acc_q : acc_rot;
  assign err_step  = err_q | malformed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_step;
    end else if (release_res) begin
      err_q <= 1'b0;
    end
  end

  logic out_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_q <= 1'b0;
    end else if (accept && bus.in_last) begin
      out_err_q <= err_step;
    end
  end
  assign bus.out_err = out_err_q;
`else
  assign acc_step    = acc_rot;
  assign err_step    = 1'b0;
  assign bus.out_err = err_step;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = HOLD;
      HOLD:    if (bus.out_ready)         state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Output decode: in_ready depends on the registered state only.
  always_comb begin
    in_ready = (state_q == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulator and result registers are all asynchronously reset, so a reset drops the
    // partial sum and any pending result at once rather than at the next edge.
    if (!rst_n) begin
      acc_q       <= OHC_ZERO;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_ohc_q   <= OHC_ZERO;
      out_bin_q   <= '0;
      out_count_q <= '0;
    end else if (accept) begin
      acc_q <= acc_step;
      cnt_q <= cnt_inc;
      if (bus.in_last) begin
        out_valid_q <= 1'b1;
        out_ohc_q   <= acc_step;
        out_bin_q   <= ohc_to_bin(acc_step);
        out_count_q <= cnt_inc;
      end
    end else if (release_res) begin
      // Result registers keep their values so the sum stays readable after out_valid falls.
      out_valid_q <= 1'b0;
      acc_q       <= OHC_ZERO;
      cnt_q       <= '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ohc   = out_ohc_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_count = out_count_q;

endmodule
